count_capture: RTL and testbench

COUNT_CAPTURE -- requirements
Module: count_capture

---
 rtl/count_capture.sv | 99 +++++++++
 tb/tb_count_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/count_capture.sv
// Event-timestamp capture: a synchronized rising edge on evt_in pushes the
// current cnt_in value into a first-word-fall-through FIFO.
module count_capture #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             cnt_in,
  input  logic                     evt_in,
  output logic [N-1:0]             cap_data,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  mem_q [DEPTH];

  logic evt_rise;
  logic full;
  logic pop;
  logic do_push;
  logic drop;

  always_comb begin
    s1_d     = evt_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    evt_rise = s2_q & ~s3_q;

    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) & cap_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push  = evt_rise & (~full | pop);
    drop     = evt_rise & full & ~pop;

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    unique case ({do_push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= cnt_in;
    end
  end

  assign cap_data  = mem_q[rd_ptr_q];
  assign cap_valid = (level_q != '0);
  assign level     = level_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: table-driven single events, hand-written multi-cycle
// sequences, and a queue scoreboard holding the expected FIFO contents.
module tb_count_capture;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  cnt_in;
  logic          evt_in;
  logic [N-1:0]  cap_data;
  logic          cap_valid;
  logic          cap_ready;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;

  count_capture #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_in    (cnt_in),
    .evt_in    (evt_in),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [N-1:0] mq [$];
  logic m_s1, m_s2, m_s3, m_ovf;

  typedef struct {
    logic [N-1:0] cnt;
    int unsigned  hold;
    logic [N-1:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/level"}, 32'(level), 32'(mq.size()));
    check({tag, "/valid"}, 32'(cap_valid), 32'(mq.size() != 0));
    check({tag, "/ovf"}, 32'(ovf), 32'(m_ovf));
    if (mq.size() != 0) check({tag, "/data"}, 32'(cap_data), 32'(mq[0]));
  endtask

  task automatic model_reset();
    mq.delete();
    m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0; m_ovf = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, update the model for the coming
  // rising edge, then compare at the next falling edge.
  task automatic cycle(input logic e, input logic [N-1:0] c, input logic r, input logic clr,
                       input string tag);
    logic push, pop, was_full;
    evt_in = e; cnt_in = c; cap_ready = r; ovf_clr = clr;
    push     = m_s2 & ~m_s3;
    was_full = (mq.size() == DEPTH);
    pop      = (mq.size() != 0) && r;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else mq.push_back(c);
    end
    if (!(push && was_full && !pop) && clr) m_ovf = 1'b0;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = e;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic event3(input logic [N-1:0] v, input logic rdy_last, input logic clr_last,
                        input string tag);
    cycle(1'b1, v, 1'b0, 1'b0, tag);
    cycle(1'b0, v, 1'b0, 1'b0, tag);
    cycle(1'b0, v, rdy_last, clr_last, tag);
  endtask

  initial begin
    int unsigned seen;
    logic [N-1:0] seen_data;

    vecs[0] = '{cnt: 4'h5, hold: 1,  exp_data: 4'h5};
    vecs[1] = '{cnt: 4'hF, hold: 10, exp_data: 4'hF};
    vecs[2] = '{cnt: 4'h0, hold: 3,  exp_data: 4'h0};
    vecs[3] = '{cnt: 4'hA, hold: 2,  exp_data: 4'hA};

    rst_n = 1'b0; evt_in = 1'b0; cnt_in = '0; cap_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset/level", 32'(level), 0);
    check("reset/valid", 32'(cap_valid), 0);
    check("reset/ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    cycle(1'b0, 4'h3, 1'b1, 1'b0, "idle_ready");

    // Single events, including a long pulse: exactly one capture each
    for (int i = 0; i < 4; i++) begin
      seen = 0;
      seen_data = '0;
      for (int unsigned k = 0; k < vecs[i].hold + 4; k++) begin
        cycle(k < vecs[i].hold, vecs[i].cnt, 1'b1, 1'b0, "vec");
        if (cap_valid) begin
          seen++;
          seen_data = cap_data;
        end
      end
      check($sformatf("vec%0d/captures", i), seen, 1);
      check($sformatf("vec%0d/data", i), 32'(seen_data), 32'(vecs[i].exp_data));
    end

    // Free-running count: value sampled at the detect edge, wrap F->0
    for (int i = 0; i < 20; i++) begin
      cycle(i inside {[2:3], [9:9], [13:18]}, 4'(i + 12), (i % 3) != 0, 1'b0, "freerun");
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, "freerun_drain");

    // Overflow: 1,3,5,7 stored, 9 dropped
    event3(4'h1, 1'b0, 1'b0, "ovf");
    event3(4'h3, 1'b0, 1'b0, "ovf");
    event3(4'h5, 1'b0, 1'b0, "ovf");
    event3(4'h7, 1'b0, 1'b0, "ovf");
    event3(4'h9, 1'b0, 1'b0, "ovf");
    check("ovf/level_full", 32'(level), DEPTH);
    check("ovf/flag", 32'(ovf), 1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
    cycle(1'b0, '0, 1'b0, 1'b1, "ovf_clear");
    check("ovf/cleared", 32'(ovf), 0);

    // Full with simultaneous push and pop; C must come out last
    event3(4'h2, 1'b0, 1'b0, "fullpp");
    event3(4'h4, 1'b0, 1'b0, "fullpp");
    event3(4'h6, 1'b0, 1'b0, "fullpp");
    event3(4'h8, 1'b0, 1'b0, "fullpp");
    event3(4'hC, 1'b1, 1'b0, "fullpp");
    check("fullpp/level", 32'(level), DEPTH);
    check("fullpp/ovf", 32'(ovf), 0);
    check("fullpp/head", 32'(cap_data), 4'h4);

    // ovf_clr coinciding with a drop: set wins, then clear alone
    event3(4'hD, 1'b0, 1'b1, "clrdrop");
    check("clrdrop/set_wins", 32'(ovf), 1);
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_alone");
    check("clr_alone/ovf", 32'(ovf), 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, "fullpp_drain");

    // Reset mid-stream with level 3, ovf set and an event in the synchronizer
    event3(4'h1, 1'b0, 1'b0, "rst_fill");
    event3(4'h2, 1'b0, 1'b0, "rst_fill");
    event3(4'h3, 1'b0, 1'b0, "rst_fill");
    event3(4'h4, 1'b0, 1'b0, "rst_fill");
    event3(4'h5, 1'b0, 1'b0, "rst_fill");
    cycle(1'b0, '0, 1'b1, 1'b0, "rst_pop");
    check("rst_pre/level", 32'(level), 3);
    check("rst_pre/ovf", 32'(ovf), 1);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, "rst_evt");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst/valid", 32'(cap_valid), 0);
    check("async_rst/level", 32'(level), 0);
    check("async_rst/ovf", 32'(ovf), 0);
    model_reset();
    evt_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h7, 1'b0, 1'b0, "post_rst_quiet");

    // evt_in held high through reset release: exactly one capture
    rst_n = 1'b0;
    evt_in = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'hB, 1'b0, 1'b0, "evt_thru_rst");
    check("evt_thru_rst/level", 32'(level), 1);
    check("evt_thru_rst/data", 32'(cap_data), 4'hB);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
